// File: rtl/pipe_hazard_sequencer_if.sv
// Control bundle between the hazard sequencer and the pipeline datapath.
// The master side raises the hazard, branch, memory and interrupt requests
// and consumes the stall, flush and PC-select controls.
interface pipe_hazard_sequencer_if;
  logic       lw_hazard_i;
  logic       branch_taken_i;
  logic       mret_i;
  logic       mem_req_i;
  logic       mem_ack_i;
  logic       irq_i;
  logic       irq_en_i;
  logic       stall_f;
  logic       stall_d;
  logic       stall_e;
  logic       flush_d;
  logic       flush_e;
  logic [1:0] pc_sel;
  logic       epc_we;
  logic [1:0] trap_cause;
  logic [2:0] state_o;

  modport master (
    output lw_hazard_i, branch_taken_i, mret_i, mem_req_i, mem_ack_i, irq_i, irq_en_i,
    input  stall_f, stall_d, stall_e, flush_d, flush_e, pc_sel, epc_we, trap_cause, state_o
  );

  modport slave (
    input  lw_hazard_i, branch_taken_i, mret_i, mem_req_i, mem_ack_i, irq_i, irq_en_i,
    output stall_f, stall_d, stall_e, flush_d, flush_e, pc_sel, epc_we, trap_cause, state_o
  );
endinterface

// File: rtl/pipe_hazard_sequencer.sv
// Pipeline-control FSM for the 3-stage core: arbitrates load-use stalls,
// branch/mret redirects, multi-cycle data memory and interrupt/timeout traps
// into one consistent set of stall/flush/PC-select controls per cycle.
// Outputs are Mealy: decoded from the registered state and the live inputs.
module pipe_hazard_sequencer #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int FLUSH_CYCLES = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  pipe_hazard_sequencer_if.slave bus
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  localparam logic [1:0] CAUSE_IRQ = 2'b01;
  localparam logic [1:0] CAUSE_TMO = 2'b10;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    MEM_WAIT = 3'd1,
    FLUSH    = 3'd2,
    TRAP     = 3'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [WCW-1:0]   wait_cnt_reg, wait_cnt_next;
  logic [FCW-1:0]   flush_cnt_reg, flush_cnt_next;
  logic             irq_pend_reg, irq_pend_next;
  logic [1:0]       cause_reg, cause_next;
  logic             irq_take;

  logic       stall_f, stall_d, stall_e, flush_d, flush_e, epc_we;
  logic [1:0] pc_sel, trap_cause;

  // State and counter registers; reset aborts any wait, flush or pending trap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= '0;
      flush_cnt_reg <= '0;
      irq_pend_reg  <= 1'b0;
      cause_reg     <= 2'b00;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
      irq_pend_reg  <= irq_pend_next;
      cause_reg     <= cause_next;
    end
  end

  // Next-state and counter logic; RUN arbitrates irq > redirect > mem wait.
  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    cause_next     = cause_reg;
    irq_take       = 1'b0;
    case (state_reg)
      RUN: begin
        if (irq_pend_reg && !bus.branch_taken_i && !bus.mem_req_i) begin
          // Interrupt waits for the E-stage branch or memory access to retire.
          state_next = TRAP;
          cause_next = CAUSE_IRQ;
          irq_take   = 1'b1;
        end else if (bus.branch_taken_i || bus.mret_i) begin
          if (FLUSH_CYCLES > 1) begin
            state_next     = FLUSH;
            flush_cnt_next = FCW'(1);
          end
        end else if (bus.mem_req_i && !bus.mem_ack_i) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = WCW'(1);
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ack_i) begin
          // Ack wins over a timeout in the same cycle.
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt_reg == WCW'(MEM_TIMEOUT - 1)) begin
          state_next    = TRAP;
          cause_next    = CAUSE_TMO;
          wait_cnt_next = '0;
        end else begin
          wait_cnt_next = wait_cnt_reg + WCW'(1);
        end
      end
      FLUSH: begin
        if (flush_cnt_reg == FCW'(FLUSH_CYCLES - 1)) begin
          state_next     = RUN;
          flush_cnt_next = '0;
        end else begin
          flush_cnt_next = flush_cnt_reg + FCW'(1);
        end
      end
      TRAP: begin
        state_next = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
    // A taken irq clears the latch even if the level is still high.
    irq_pend_next = irq_take ? 1'b0 : (irq_pend_reg | (bus.irq_i & bus.irq_en_i));
  end

  // Mealy output decode; flush dominates stall on a stage, reset forces all low.
  always_comb begin
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    pc_sel     = 2'b00;
    epc_we     = 1'b0;
    trap_cause = 2'b00;
    case (state_reg)
      RUN: begin
        if (irq_pend_reg && !bus.branch_taken_i && !bus.mem_req_i) begin
          // Decision cycle only; the redirect happens in TRAP.
        end else if (bus.branch_taken_i || bus.mret_i) begin
          flush_d = 1'b1;
          pc_sel  = bus.mret_i ? 2'b11 : 2'b01;
        end else if (bus.mem_req_i && !bus.mem_ack_i) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
        end else if (bus.lw_hazard_i) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!bus.mem_ack_i) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
        end
      end
      FLUSH: begin
        flush_d = 1'b1;
      end
      TRAP: begin
        pc_sel     = 2'b10;
        flush_d    = 1'b1;
        flush_e    = 1'b1;
        epc_we     = 1'b1;
        trap_cause = cause_reg;
      end
      default: begin
      end
    endcase
    stall_d = stall_d & ~flush_d;
    stall_e = stall_e & ~flush_e;
    if (!rst_n) begin
      stall_f    = 1'b0;
      stall_d    = 1'b0;
      stall_e    = 1'b0;
      flush_d    = 1'b0;
      flush_e    = 1'b0;
      pc_sel     = 2'b00;
      epc_we     = 1'b0;
      trap_cause = 2'b00;
    end
  end

  assign bus.stall_f    = stall_f;
  assign bus.stall_d    = stall_d;
  assign bus.stall_e    = stall_e;
  assign bus.flush_d    = flush_d;
  assign bus.flush_e    = flush_e;
  assign bus.pc_sel     = pc_sel;
  assign bus.epc_we     = epc_we;
  assign bus.trap_cause = trap_cause;
  assign bus.state_o    = state_reg;

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Bench for pipe_hazard_sequencer: instance A uses default parameters,
// instance B uses FLUSH_CYCLES=3. Each step drives inputs and pushes the
// expected Mealy outputs; a negedge monitor pops and compares them.
module tb_pipe_hazard_sequencer;

  logic clk;
  logic rst_n;

  pipe_hazard_sequencer_if bus_a ();
  pipe_hazard_sequencer_if bus_b ();

  pipe_hazard_sequencer #(.MEM_TIMEOUT(16), .FLUSH_CYCLES(1)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (bus_a.slave)
  );
  pipe_hazard_sequencer #(.MEM_TIMEOUT(16), .FLUSH_CYCLES(3)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input vector bits: {lw, br, mret, req, ack, irq, irq_en}
  localparam logic [6:0] I_NONE = 7'b000_0000;
  localparam logic [6:0] I_LW   = 7'b100_0000;
  localparam logic [6:0] I_BR   = 7'b010_0000;
  localparam logic [6:0] I_MRET = 7'b001_0000;
  localparam logic [6:0] I_REQ  = 7'b000_1000;
  localparam logic [6:0] I_ACK  = 7'b000_0100;
  localparam logic [6:0] I_IRQ  = 7'b000_0011;

  typedef struct {
    logic [12:0] exp;
    bit          is_b;
    int          step_no;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  step_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected vector {sf,sd,se,fd,fe,pc_sel,epc_we,trap_cause,state}
  function automatic logic [12:0] mk(input logic sf, input logic sd, input logic se,
                                     input logic fd, input logic fe, input logic [1:0] pc,
                                     input logic epc, input logic [1:0] cause, input logic [2:0] st);
    return {sf, sd, se, fd, fe, pc, epc, cause, st};
  endfunction

  function automatic logic [12:0] obs_a();
    return {bus_a.stall_f, bus_a.stall_d, bus_a.stall_e, bus_a.flush_d, bus_a.flush_e,
            bus_a.pc_sel, bus_a.epc_we, bus_a.trap_cause, bus_a.state_o};
  endfunction

  function automatic logic [12:0] obs_b();
    return {bus_b.stall_f, bus_b.stall_d, bus_b.stall_e, bus_b.flush_d, bus_b.flush_e,
            bus_b.pc_sel, bus_b.epc_we, bus_b.trap_cause, bus_b.state_o};
  endfunction

  task automatic drive_a(input logic [6:0] v);
    {bus_a.lw_hazard_i, bus_a.branch_taken_i, bus_a.mret_i, bus_a.mem_req_i,
     bus_a.mem_ack_i, bus_a.irq_i, bus_a.irq_en_i} = v;
  endtask

  task automatic drive_b(input logic [6:0] v);
    {bus_b.lw_hazard_i, bus_b.branch_taken_i, bus_b.mret_i, bus_b.mem_req_i,
     bus_b.mem_ack_i, bus_b.irq_i, bus_b.irq_en_i} = v;
  endtask

  // One clock of stimulus on both instances plus their expected outputs.
  task automatic step2(input logic [6:0] in_a, input logic [12:0] exp_a,
                       input logic [6:0] in_b, input logic [12:0] exp_b);
    sb_t e;
    @(posedge clk);
    #1;
    drive_a(in_a);
    drive_b(in_b);
    step_cnt++;
    e.exp = exp_a; e.is_b = 1'b0; e.step_no = step_cnt; sb_q.push_back(e);
    e.exp = exp_b; e.is_b = 1'b1; e.step_no = step_cnt; sb_q.push_back(e);
  endtask

  task automatic step_a(input logic [6:0] in_a, input logic [12:0] exp_a);
    step2(in_a, exp_a, I_NONE, mk(0,0,0,0,0,2'b00,0,2'b00,3'd0));
  endtask

  // Scoreboard monitor: compare every queued expectation mid-cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      if (e.is_b) check_val($sformatf("step%0d_b", e.step_no), 32'(obs_b()), 32'(e.exp));
      else        check_val($sformatf("step%0d_a", e.step_no), 32'(obs_a()), 32'(e.exp));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  localparam logic [12:0] Z0    = 13'd0;
  localparam logic [12:0] STALL3_RUN  = 13'b111_00_00_0_00_000;
  localparam logic [12:0] STALL3_WAIT = 13'b111_00_00_0_00_001;

  initial begin
    rst_n = 1'b0;
    drive_a(I_NONE);
    drive_b(I_NONE);
    #3;
    check_val("reset_a", 32'(obs_a()), 32'd0);
    check_val("reset_b", 32'(obs_b()), 32'd0);
    #20;
    rst_n = 1'b1;

    // Load-use: one bubble for exactly one cycle.
    step_a(I_LW,   mk(1,1,0,0,1,2'b00,0,2'b00,3'd0));
    step_a(I_NONE, Z0);

    // Mem wait: ack on the fourth cycle.
    step_a(I_REQ,         STALL3_RUN);
    step_a(I_REQ,         STALL3_WAIT);
    step_a(I_REQ,         STALL3_WAIT);
    step_a(I_REQ | I_ACK, mk(0,0,0,0,0,2'b00,0,2'b00,3'd1));
    step_a(I_NONE,        Z0);

    // Single-cycle access: no stall.
    step_a(I_REQ | I_ACK, Z0);

    // Timeout: 16 stall cycles then one TRAP cycle with cause 10.
    step_a(I_REQ, STALL3_RUN);
    for (int i = 0; i < 15; i++) step_a(I_REQ, STALL3_WAIT);
    step_a(I_NONE, mk(0,0,0,1,1,2'b10,1,2'b10,3'd3));
    step_a(I_NONE, Z0);

    // Ack on the timeout cycle wins: no trap.
    step_a(I_REQ, STALL3_RUN);
    for (int i = 0; i < 14; i++) step_a(I_REQ, STALL3_WAIT);
    step_a(I_REQ | I_ACK, mk(0,0,0,0,0,2'b00,0,2'b00,3'd1));
    step_a(I_NONE, Z0);
    step_a(I_NONE, Z0);

    // Collision: irq latched while a memory access blocks it, then branch + lw_hazard.
    step_a(I_IRQ | I_REQ | I_ACK, Z0);
    step_a(I_BR | I_LW,           mk(0,0,0,1,0,2'b01,0,2'b00,3'd0));
    step_a(I_NONE,                Z0);
    step_a(I_NONE,                mk(0,0,0,1,1,2'b10,1,2'b01,3'd3));
    step_a(I_NONE,                Z0);
    step_a(I_NONE,                Z0);

    // Branch and mret together: mret target wins.
    step_a(I_BR | I_MRET, mk(0,0,0,1,0,2'b11,0,2'b00,3'd0));
    step_a(I_NONE,        Z0);

    // FLUSH_CYCLES=3 on instance B: mret redirect then two FLUSH cycles.
    step2(I_NONE, Z0, I_MRET, mk(0,0,0,1,0,2'b11,0,2'b00,3'd0));
    step2(I_NONE, Z0, I_NONE, mk(0,0,0,1,0,2'b00,0,2'b00,3'd2));
    step2(I_NONE, Z0, I_NONE, mk(0,0,0,1,0,2'b00,0,2'b00,3'd2));
    step2(I_NONE, Z0, I_NONE, Z0);

    // Reset mid MEM_WAIT with wait_cnt=5, irq latched during the wait.
    step_a(I_REQ, STALL3_RUN);
    for (int i = 0; i < 4; i++) step_a(I_REQ | I_IRQ, STALL3_WAIT);
    @(posedge clk);
    #1;
    drive_a(I_REQ);
    #2;
    check_val("rst_pre_stall_e", 32'(bus_a.stall_e), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rst_async_outs", 32'(obs_a()), 32'd0);
    drive_a(I_NONE);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    // Latched irq and wait are gone: no trap follows.
    step_a(I_NONE, Z0);
    step_a(I_NONE, Z0);
    step_a(I_NONE, Z0);

    begin
      int guard;
      guard = 0;
      while (sb_q.size() > 0 && guard < 10) begin
        @(posedge clk);
        guard++;
      end
      @(posedge clk);
      check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
